// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common-data-bus arbiter.
//   CDB_LANES     default number of CDB broadcast lanes
//   fu_cdb_reg_t  payload a functional unit hands to the CDB
//   ptr_width()   bit width needed to hold an index into n requesters
package cdb_arbiter_pkg;

   localparam int CDB_LANES = 2;

   typedef struct packed {
      logic [5:0]  rob_id;
      logic [4:0]  rd_arch;
      logic [6:0]  rd_phy;
      logic [31:0] rd_value;
      logic [31:0] dbg_pc;
   } fu_cdb_reg_t;

   // A single requester still needs a one-bit pointer so the ports stay legal.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_rr_pick.sv
// Combinational round-robin picker: finds the first set bit of req_mask
// scanning start_ptr, start_ptr+1, ... modulo NUM_REQ.
//   req_mask   in   NUM_REQ   candidate requesters
//   start_ptr  in   PTR_W     index where the scan begins
//   grant_oh   out  NUM_REQ   one-hot of the chosen requester (0 if none)
//   grant_idx  out  PTR_W     index of the chosen requester (0 if none)
//   found      out  1         a requester was chosen
module cdb_rr_pick
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_mask,
   input  logic [PTR_W-1:0]   start_ptr,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic [PTR_W-1:0]   grant_idx,
   output logic               found
);

   logic [PTR_W-1:0] cand;

   // The found flag stops later candidates from overriding the first hit.
   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = PTR_W'((int'(start_ptr) + k) % NUM_REQ);
         if (!found && req_mask[cand]) begin
            found          = 1'b1;
            grant_oh[cand] = 1'b1;
            grant_idx      = cand;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing NUM_LANES CDB lanes among NUM_REQ FU requesters.
// Grants are combinational (req_ready); granted payloads appear one cycle
// later on the registered cdb_valid/cdb_data lanes.
//   clk, rst    clock and synchronous active-high reset
//   flush       drops this cycle's grants, pointer holds
//   req_valid   per-requester result pending
//   req_data    per-requester payload
//   req_ready   per-requester grant (only where req_valid is set)
//   cdb_valid   per-lane registered valid, filled contiguously from lane 0
//   cdb_data    per-lane registered payload, holds when the lane is idle
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int NUM_LANES = CDB_LANES
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  fu_cdb_reg_t          req_data [NUM_REQ],
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [NUM_LANES-1:0] cdb_valid,
   output fu_cdb_reg_t          cdb_data [NUM_LANES]
);

   localparam int PTR_W = ptr_width(NUM_REQ);

   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_LANES-1:0] cdb_valid_q, cdb_valid_d;
   fu_cdb_reg_t          cdb_data_q [NUM_LANES];
   fu_cdb_reg_t          cdb_data_d [NUM_LANES];

   logic [NUM_REQ-1:0]   base_mask;
   logic [NUM_REQ-1:0]   lane_grant [NUM_LANES];
   logic [PTR_W-1:0]     lane_idx   [NUM_LANES];
   logic [NUM_LANES-1:0] lane_found;

   // Reset and flush suppress every grant at the source of the picker chain.
   assign base_mask = (rst || flush) ? '0 : req_valid;

   // Each lane scans from the same pointer; removing earlier grants from its
   // mask makes it land on the next valid requester in rotation order.
   for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      logic [NUM_REQ-1:0] mask;
      logic [NUM_REQ-1:0] grant;

      if (l == 0) begin : g_first
         assign mask = base_mask;
      end else begin : g_next
         assign mask = g_lane[l-1].mask & ~g_lane[l-1].grant;
      end

      cdb_rr_pick #(
         .NUM_REQ (NUM_REQ),
         .PTR_W   (PTR_W)
      ) u_pick (
         .req_mask  (mask),
         .start_ptr (rr_ptr_q),
         .grant_oh  (grant),
         .grant_idx (lane_idx[l]),
         .found     (lane_found[l])
      );

      assign lane_grant[l] = grant;
   end

   always_comb begin
      req_ready = '0;
      for (int l = 0; l < NUM_LANES; l++) begin
         req_ready = req_ready | lane_grant[l];
      end
   end

   // Lanes fill in order, so the highest found lane holds the last grant and
   // its successor becomes the new pointer; with no grant the pointer holds.
   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      cdb_valid_d = lane_found;
      for (int l = 0; l < NUM_LANES; l++) begin
         cdb_data_d[l] = cdb_data_q[l];
         if (lane_found[l]) begin
            cdb_data_d[l] = req_data[lane_idx[l]];
            rr_ptr_d      = (lane_idx[l] == PTR_W'(NUM_REQ - 1)) ? '0 : lane_idx[l] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= '0;
         for (int l = 0; l < NUM_LANES; l++) begin
            cdb_data_q[l] <= '0;
         end
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         for (int l = 0; l < NUM_LANES; l++) begin
            cdb_data_q[l] <= cdb_data_d[l];
         end
      end
   end

   assign cdb_valid = cdb_valid_q;
   assign cdb_data  = cdb_data_q;

endmodule
